// File: rtl/encoder_pkg.sv
// Shared types and helpers for the input-side event encoder.
// Holds the FSM state type and the index-to-code mapping used so that
// codes match the output decoder's code space (1..N, 0 means none).
package encoder_pkg;

   typedef enum logic {IDLE, HOLD} enc_state_t;

   // Line index i is reported as code i+1; code 0 is reserved for "no event".
   function automatic int unsigned idx_to_code(input int unsigned idx);
      return idx + 1;
   endfunction

endpackage

// File: rtl/encoder_for_in_rr_index_picker.sv
// Combinational round-robin search over pending event flags.
// Ports:
//   pending_i    - per-line pending flags (registered view)
//   last_code_i  - code most recently handed out (0 = none yet)
//   pick_code_o  - code of the chosen line, 0 when nothing is pending
//   pick_valid_o - a pending line was found
module rr_index_picker
   import encoder_pkg::*;
#(
   parameter int IN_SIZE = 7,
   parameter int CODE_W  = $clog2(IN_SIZE + 1)
) (
   input  logic [IN_SIZE-1:0] pending_i,
   input  logic [CODE_W-1:0]  last_code_i,
   output logic [CODE_W-1:0]  pick_code_o,
   output logic               pick_valid_o
);

   always_comb begin
      int unsigned        idx;
      logic [IN_SIZE-1:0] shifted;
      pick_code_o  = '0;
      pick_valid_o = 1'b0;
      idx          = 0;
      shifted      = '0;
      // Search begins at the line after last_code (index == last_code), wrapping.
      for (int off = 0; off < IN_SIZE; off++) begin
         idx     = (int'(last_code_i) + off) % IN_SIZE;
         shifted = pending_i >> idx;
         if (!pick_valid_o && shifted[0]) begin
            pick_valid_o = 1'b1;
            pick_code_o  = CODE_W'(idx_to_code(idx));
         end
      end
   end

endmodule

// File: rtl/encoder_for_in.sv
// Input-side event encoder: synchronizes IN_SIZE asynchronous lines,
// turns rising edges into per-line pending events and hands them out
// one at a time as 1-based codes over a valid/ready interface with
// round-robin fairness.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   in_lines   - asynchronous input lines; line i reports code i+1
//   code_o     - event code (0 when valid_o=0)
//   valid_o    - code_o holds an event
//   ready_i    - consumer accepts code_o when valid_o && ready_i
//   pending_o  - per-line pending-event flags
//   ovf_o      - sticky per-line overflow flags (event lost)
//   clr_ovf_i  - clears all overflow flags
module encoder_for_in
   import encoder_pkg::*;
#(
   parameter int IN_SIZE = 7
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [IN_SIZE-1:0]               in_lines,
   output logic [$clog2(IN_SIZE+1)-1:0]     code_o,
   output logic                             valid_o,
   input  logic                             ready_i,
   output logic [IN_SIZE-1:0]               pending_o,
   output logic [IN_SIZE-1:0]               ovf_o,
   input  logic                             clr_ovf_i
);

   localparam int CODE_W = $clog2(IN_SIZE + 1);

   logic [IN_SIZE-1:0] s1_q, s2_q, prev_q;
   logic [IN_SIZE-1:0] pending_q, pending_d;
   logic [IN_SIZE-1:0] ovf_q, ovf_d;
   logic [CODE_W-1:0]  last_code_q, last_code_d;
   logic [CODE_W-1:0]  code_q, code_d;
   logic               valid_q, valid_d;
   enc_state_t         state_q, state_d;

   logic [IN_SIZE-1:0] edge_det;
   logic [IN_SIZE-1:0] clr_mask;
   logic [IN_SIZE-1:0] new_ovf;
   logic [CODE_W-1:0]  pick_code;
   logic               pick_valid;
   logic               load;

   assign edge_det = s2_q & ~prev_q;

   rr_index_picker #(
      .IN_SIZE (IN_SIZE),
      .CODE_W  (CODE_W)
   ) u_picker (
      .pending_i    (pending_q),
      .last_code_i  (last_code_q),
      .pick_code_o  (pick_code),
      .pick_valid_o (pick_valid)
   );

   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      valid_d     = valid_q;
      last_code_d = last_code_q;
      load        = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               load = 1'b1;
            end
         end
         HOLD: begin
            if (ready_i) begin
               if (pick_valid) begin
                  load = 1'b1;
               end else begin
                  valid_d = 1'b0;
                  code_d  = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         code_d      = pick_code;
         valid_d     = 1'b1;
         last_code_d = pick_code;
         state_d     = HOLD;
      end
   end

   // A load only happens with pick_valid, so pick_code is at least 1 here.
   assign clr_mask = load ? (IN_SIZE'(1) << (pick_code - CODE_W'(1))) : '0;

   // Set beats clear: a fresh edge on the line being loaded is a second event.
   assign pending_d = (pending_q & ~clr_mask) | edge_det;

   // An edge landing on a still-pending line is merged into it, i.e. lost.
   assign new_ovf = edge_det & pending_q & ~clr_mask;
   assign ovf_d   = (clr_ovf_i ? '0 : ovf_q) | new_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q        <= '0;
         s2_q        <= '0;
         prev_q      <= '0;
         pending_q   <= '0;
         ovf_q       <= '0;
         last_code_q <= '0;
         code_q      <= '0;
         valid_q     <= 1'b0;
         state_q     <= IDLE;
      end else begin
         s1_q        <= in_lines;
         s2_q        <= s1_q;
         prev_q      <= s2_q;
         pending_q   <= pending_d;
         ovf_q       <= ovf_d;
         last_code_q <= last_code_d;
         code_q      <= code_d;
         valid_q     <= valid_d;
         state_q     <= state_d;
      end
   end

   assign code_o    = code_q;
   assign valid_o   = valid_q;
   assign pending_o = pending_q;
   assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_encoder_for_in.sv
// Scoreboard bench for encoder_for_in (IN_SIZE=7): stimulus pushes the
// expected codes, a negedge monitor pops them on each accepted handshake.
module tb_encoder_for_in;

   localparam int IN_SIZE = 7;
   localparam int CODE_W  = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [IN_SIZE-1:0] in_lines = '0;
   logic [CODE_W-1:0]  code_o;
   logic               valid_o;
   logic               ready_i = 1'b0;
   logic [IN_SIZE-1:0] pending_o;
   logic [IN_SIZE-1:0] ovf_o;
   logic               clr_ovf_i = 1'b0;

   int checks   = 0;
   int failures = 0;
   int sb[$];

   encoder_for_in #(.IN_SIZE(IN_SIZE)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_lines  (in_lines),
      .code_o    (code_o),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .pending_o (pending_o),
      .ovf_o     (ovf_o),
      .clr_ovf_i (clr_ovf_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      in_lines  = '0;
      ready_i   = 1'b0;
      clr_ovf_i = 1'b0;
      rst       = 1'b1;
      tick();
      tick();
      rst       = 1'b0;
   endtask

   // Monitor: every accepted handshake must match the oldest expected code.
   always @(negedge clk) begin
      int exp_code;
      if (!rst && valid_o && ready_i) begin
         if (sb.size() == 0) begin
            chk("unexpected_code", 32'(code_o), 32'(0));
         end else begin
            exp_code = sb.pop_front();
            chk("handshake_code", 32'(code_o), 32'(exp_code));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. Reset state and single event latency
      reset_dut();
      chk("rst_valid",   32'(valid_o),   32'(0));
      chk("rst_code",    32'(code_o),    32'(0));
      chk("rst_pending", 32'(pending_o), 32'(0));
      chk("rst_ovf",     32'(ovf_o),     32'(0));
      repeat (5) tick();
      ready_i  = 1'b1;
      in_lines = 7'b0000100;
      sb.push_back(3);
      tick(); tick(); tick();
      chk("t1_pending_k2", 32'(pending_o), 32'(7'b0000100));
      chk("t1_valid_k2",   32'(valid_o),   32'(0));
      tick();
      chk("t1_valid_k3", 32'(valid_o), 32'(1));
      chk("t1_code_k3",  32'(code_o),  32'(3));
      tick();
      chk("t1_valid_after", 32'(valid_o),   32'(0));
      chk("t1_code_after",  32'(code_o),    32'(0));
      chk("t1_pend_after",  32'(pending_o), 32'(0));

      // 2. Backpressure
      reset_dut();
      in_lines = 7'b0010001;
      sb.push_back(1);
      sb.push_back(5);
      repeat (4) tick();
      for (int i = 0; i < 10; i++) begin
         chk("t2_hold", 32'({valid_o, code_o}), 32'({1'b1, 3'd1}));
         tick();
      end
      ready_i = 1'b1;
      tick();
      chk("t2_second_code", 32'(code_o), 32'(5));
      tick();
      chk("t2_idle", 32'(valid_o), 32'(0));

      // 3. Round robin
      reset_dut();
      ready_i  = 1'b1;
      in_lines = 7'b1000011;
      sb.push_back(1);
      sb.push_back(2);
      sb.push_back(7);
      repeat (7) tick();
      chk("t3_idle_a", 32'(valid_o),   32'(0));
      chk("t3_pend_a", 32'(pending_o), 32'(0));
      in_lines = '0;
      repeat (4) tick();
      in_lines = 7'b1000001;
      sb.push_back(1);
      sb.push_back(7);
      repeat (6) tick();
      chk("t3_idle_b", 32'(valid_o), 32'(0));

      // 4. Overflow: line 0 occupies HOLD so line 3 stays pending
      reset_dut();
      in_lines = 7'b0000001;
      sb.push_back(1);
      repeat (4) tick();
      in_lines = 7'b0001001;
      repeat (4) tick();
      in_lines = 7'b0000001;
      repeat (4) tick();
      in_lines = 7'b0001001;
      repeat (4) tick();
      chk("t4_ovf",  32'(ovf_o),     32'(7'b0001000));
      chk("t4_pend", 32'(pending_o), 32'(7'b0001000));
      sb.push_back(4);
      ready_i = 1'b1;
      repeat (4) tick();
      chk("t4_idle", 32'(valid_o), 32'(0));
      ready_i   = 1'b0;
      clr_ovf_i = 1'b1;
      tick();
      clr_ovf_i = 1'b0;
      chk("t4_ovf_clr", 32'(ovf_o), 32'(0));
      // clear coinciding with a fresh overflow
      reset_dut();
      in_lines = 7'b0000001;
      sb.push_back(1);
      repeat (4) tick();
      in_lines = 7'b0001001;
      repeat (4) tick();
      in_lines = 7'b0000001;
      repeat (4) tick();
      in_lines = 7'b0001001;
      tick(); tick();
      clr_ovf_i = 1'b1;
      tick();
      clr_ovf_i = 1'b0;
      chk("t4_ovf_wins", 32'(ovf_o), 32'(7'b0001000));
      sb.push_back(4);
      ready_i = 1'b1;
      repeat (4) tick();
      chk("t4_idle_b", 32'(valid_o), 32'(0));

      // 5. Set/clear collision on line 2
      reset_dut();
      in_lines = 7'b0000001;
      sb.push_back(1);
      repeat (4) tick();
      in_lines = 7'b0000101;
      repeat (3) tick();
      in_lines = 7'b0000001;
      repeat (4) tick();
      in_lines = 7'b0000101;
      sb.push_back(3);
      sb.push_back(3);
      tick(); tick();
      ready_i = 1'b1;
      tick();
      chk("t5_pend_kept", 32'(pending_o), 32'(7'b0000100));
      chk("t5_code",      32'(code_o),    32'(3));
      chk("t5_no_ovf",    32'(ovf_o),     32'(0));
      tick();
      chk("t5_code_again", 32'({valid_o, code_o}), 32'({1'b1, 3'd3}));
      tick();
      chk("t5_idle", 32'(valid_o), 32'(0));

      // 6. Reset mid-operation
      reset_dut();
      in_lines = 7'b0001111;
      repeat (5) tick();
      in_lines = 7'b0000001;
      repeat (4) tick();
      in_lines = 7'b0001111;
      repeat (3) tick();
      chk("t6_hold_code", 32'({valid_o, code_o}), 32'({1'b1, 3'd1}));
      chk("t6_ovf_pre",   32'(ovf_o),             32'(7'b0001110));
      rst = 1'b1;
      tick();
      chk("t6_rst_valid", 32'(valid_o),   32'(0));
      chk("t6_rst_code",  32'(code_o),    32'(0));
      chk("t6_rst_pend",  32'(pending_o), 32'(0));
      chk("t6_rst_ovf",   32'(ovf_o),     32'(0));
      rst = 1'b0;
      sb.push_back(1);
      sb.push_back(2);
      sb.push_back(3);
      sb.push_back(4);
      tick(); tick(); tick();
      chk("t6_pend_k2",  32'(pending_o), 32'(7'b0001111));
      chk("t6_valid_k2", 32'(valid_o),   32'(0));
      tick();
      chk("t6_valid_k3", 32'({valid_o, code_o}), 32'({1'b1, 3'd1}));
      ready_i = 1'b1;
      repeat (6) tick();
      chk("t6_idle", 32'(valid_o), 32'(0));

      chk("sb_drained", 32'(sb.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
